// File: rtl/refinement_check_monitor.sv
// refinement_check_monitor: sequences one spec-vs-impl check per issue with masked compare, timeout and sticky fail.
module refinement_check_monitor #(
  parameter int DW      = 8,
  parameter int NCH     = 4,
  parameter int CW      = 4,
  parameter int CNT_MAX = 6,
  parameter int REARM   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic [CW-1:0]     end_cyc_i,
  input  logic [NCH*DW-1:0] spec_val_i,
  input  logic [NCH*DW-1:0] impl_val_i,
  input  logic [NCH-1:0]    chk_mask_i,
  output logic              start_o,
  output logic              started_o,
  output logic [CW-1:0]     cycle_cnt_o,
  output logic              ended_o,
  output logic              end2_o,
  output logic              resetted_o,
  output logic [NCH-1:0]    match_o,
  output logic              mismatch_o,
  output logic              timeout_o,
  output logic              fail_o,
  output logic [7:0]        checks_done_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_END1, S_HOLD} state_t;
  localparam logic [CW-1:0] CMAX = CW'(CNT_MAX);
  state_t r_state, w_next;
  logic [CW-1:0] r_tgt, r_cnt;
  logic r_started, r_ended, r_end2, r_resetted, r_mismatch, r_timeout, r_fail;
  logic [NCH-1:0] r_match, w_cmp;
  logic [7:0] r_done;
  logic w_iend, w_to, w_run, w_count;
  for (genvar g = 0; g < NCH; g++) begin : g_cmp
    assign w_cmp[g] = !chk_mask_i[g] || (impl_val_i[g*DW+:DW] == spec_val_i[g*DW+:DW]);
  end
  assign w_run   = r_state == S_RUN;
  assign w_iend  = r_started && r_cnt == r_tgt && !r_ended && r_resetted;
  assign w_to    = r_tgt > CMAX && r_cnt == CMAX;
  assign w_count = (r_state == S_START || w_run || r_state == S_END1) && r_cnt < CMAX;
  always_ff @(posedge clk)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == S_IDLE && issue_i) ? S_START :
             r_state == S_START             ? S_RUN :
             (w_run && w_iend)              ? S_END1 :
             (w_run && w_to)                ? S_HOLD :
             r_state == S_END1              ? (REARM != 0 ? S_IDLE : S_HOLD) :
                                              r_state;
  always_comb begin
    start_o       = r_state == S_START;
    started_o     = r_started;
    cycle_cnt_o   = r_cnt;
    ended_o       = r_ended;
    end2_o        = r_end2;
    resetted_o    = r_resetted;
    match_o       = r_match;
    mismatch_o    = r_mismatch;
    timeout_o     = r_timeout;
    fail_o        = r_fail;
    checks_done_o = r_done;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_tgt      <= '0;
      r_cnt      <= '0;
      r_started  <= 1'b0;
      r_ended    <= 1'b0;
      r_end2     <= 1'b0;
      r_resetted <= 1'b1;
      r_match    <= '1;
      r_mismatch <= 1'b0;
      r_timeout  <= 1'b0;
      r_fail     <= 1'b0;
      r_done     <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (r_state == S_IDLE && issue_i) r_tgt <= (end_cyc_i == '0) ? CW'(1) : end_cyc_i;
      if (r_state == S_START) r_started <= 1'b1;
      if (w_count) r_cnt <= r_cnt + CW'(1);
      if (w_run && w_iend) begin
        r_match    <= w_cmp;
        r_mismatch <= !(&w_cmp);
        r_ended    <= 1'b1;
        if (!(&w_cmp)) r_fail <= 1'b1;
      end
      if (w_run && w_to) begin
        r_timeout <= 1'b1;
        r_fail    <= 1'b1;
      end
      if (r_state == S_END1) begin
        r_end2 <= 1'b1;
        if (r_done != 8'hFF) r_done <= r_done + 8'd1;
        // re-arm wipes the per-check progress but keeps results and sticky flags
        if (REARM != 0) begin
          r_started <= 1'b0;
          r_ended   <= 1'b0;
          r_end2    <= 1'b0;
          r_cnt     <= '0;
        end
      end
    end
endmodule

// File: tb/tb_refinement_check_monitor.sv
// tb_refinement_check_monitor: directed vectors against one-shot and re-arming instances.
module tb_refinement_check_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_i = 1'b0;
  logic [3:0] end_cyc_i = '0;
  logic [31:0] spec_val_i = '0;
  logic [31:0] impl_val_i = '0;
  logic [3:0] chk_mask_i = 4'hF;
  logic start_o, started_o, ended_o, end2_o, resetted_o, mismatch_o, timeout_o, fail_o;
  logic [3:0] cycle_cnt_o, match_o;
  logic [7:0] checks_done_o;
  logic r_start, r_started, r_ended, r_end2, r_resetted, r_mismatch, r_timeout, r_fail;
  logic [3:0] r_cnt, r_match;
  logic [7:0] r_done;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  refinement_check_monitor dut (
    .clk(clk), .rst(rst), .issue_i(issue_i), .end_cyc_i(end_cyc_i),
    .spec_val_i(spec_val_i), .impl_val_i(impl_val_i), .chk_mask_i(chk_mask_i),
    .start_o(start_o), .started_o(started_o), .cycle_cnt_o(cycle_cnt_o),
    .ended_o(ended_o), .end2_o(end2_o), .resetted_o(resetted_o), .match_o(match_o),
    .mismatch_o(mismatch_o), .timeout_o(timeout_o), .fail_o(fail_o),
    .checks_done_o(checks_done_o)
  );
  refinement_check_monitor #(.REARM(1)) dut_r (
    .clk(clk), .rst(rst), .issue_i(issue_i), .end_cyc_i(end_cyc_i),
    .spec_val_i(spec_val_i), .impl_val_i(impl_val_i), .chk_mask_i(chk_mask_i),
    .start_o(r_start), .started_o(r_started), .cycle_cnt_o(r_cnt),
    .ended_o(r_ended), .end2_o(r_end2), .resetted_o(r_resetted), .match_o(r_match),
    .mismatch_o(r_mismatch), .timeout_o(r_timeout), .fail_o(r_fail),
    .checks_done_o(r_done)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".start"}, start_o, 0);
    chk({tag, ".started"}, started_o, 0);
    chk({tag, ".cnt"}, cycle_cnt_o, 0);
    chk({tag, ".ended"}, ended_o, 0);
    chk({tag, ".end2"}, end2_o, 0);
    chk({tag, ".resetted"}, resetted_o, 1);
    chk({tag, ".match"}, match_o, 4'hF);
    chk({tag, ".mismatch"}, mismatch_o, 0);
    chk({tag, ".timeout"}, timeout_o, 0);
    chk({tag, ".fail"}, fail_o, 0);
    chk({tag, ".done"}, checks_done_o, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    issue_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic pass_check(input string tag, input logic [3:0] ec);
    do_reset();
    spec_val_i = 32'h5A5A5A5A;
    impl_val_i = 32'h5A5A5A5A;
    chk_mask_i = 4'hF;
    end_cyc_i = ec;
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    chk({tag, ".c1.start"}, start_o, 1);
    chk({tag, ".c1.started"}, started_o, 0);
    tick();
    chk({tag, ".c2.start"}, start_o, 0);
    chk({tag, ".c2.started"}, started_o, 1);
    chk({tag, ".c2.cnt"}, cycle_cnt_o, 1);
    chk({tag, ".c2.ended"}, ended_o, 0);
    tick();
    chk({tag, ".c3.ended"}, ended_o, 1);
    chk({tag, ".c3.match"}, match_o, 4'hF);
    chk({tag, ".c3.mismatch"}, mismatch_o, 0);
    chk({tag, ".c3.end2"}, end2_o, 0);
    tick();
    chk({tag, ".c4.end2"}, end2_o, 1);
    chk({tag, ".c4.done"}, checks_done_o, 1);
    chk({tag, ".c4.mismatch"}, mismatch_o, 0);
    chk({tag, ".c4.cnt"}, cycle_cnt_o, 3);
    tick();
    chk({tag, ".hold.cnt"}, cycle_cnt_o, 3);
    chk({tag, ".hold.done"}, checks_done_o, 1);
    chk({tag, ".hold.fail"}, fail_o, 0);
  endtask
  task automatic mask_check(input string tag, input logic [3:0] mask, input logic [3:0] exp_match,
                            input logic exp_fail);
    do_reset();
    spec_val_i = 32'h5A105A5A;
    impl_val_i = 32'h5A115A5A;
    chk_mask_i = mask;
    end_cyc_i = 4'd3;
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    tick();
    tick();
    tick();
    chk({tag, ".pre.cnt"}, cycle_cnt_o, 3);
    chk({tag, ".pre.ended"}, ended_o, 0);
    chk({tag, ".pre.mismatch"}, mismatch_o, 0);
    tick();
    chk({tag, ".iend.ended"}, ended_o, 1);
    chk({tag, ".iend.match"}, match_o, exp_match);
    chk({tag, ".iend.mismatch"}, mismatch_o, exp_fail);
    chk({tag, ".iend.fail"}, fail_o, exp_fail);
    tick();
    chk({tag, ".post.mismatch"}, mismatch_o, 0);
    chk({tag, ".post.fail"}, fail_o, exp_fail);
    chk({tag, ".post.end2"}, end2_o, 1);
    tick();
    chk({tag, ".hold.fail"}, fail_o, exp_fail);
    chk({tag, ".hold.match"}, match_o, exp_match);
  endtask
  initial begin
    do_reset();
    chk_reset("reset");
    pass_check("pass", 4'd1);
    mask_check("mis", 4'hF, 4'hB, 1'b1);
    mask_check("masked", 4'hB, 4'hF, 1'b0);
    // timeout: end cycle 9 can never be reached with the counter saturating at 6
    do_reset();
    spec_val_i = 32'h5A5A5A5A;
    impl_val_i = 32'h5A5A5A5A;
    chk_mask_i = 4'hF;
    end_cyc_i = 4'd9;
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("to.pre.cnt", cycle_cnt_o, 6);
    chk("to.pre.timeout", timeout_o, 0);
    tick();
    chk("to.timeout", timeout_o, 1);
    chk("to.fail", fail_o, 1);
    chk("to.ended", ended_o, 0);
    chk("to.cnt", cycle_cnt_o, 6);
    issue_i = 1'b1;
    tick();
    tick();
    chk("to.hold.start", start_o, 0);
    chk("to.hold.cnt", cycle_cnt_o, 6);
    chk("to.hold.timeout", timeout_o, 1);
    chk("to.hold.done", checks_done_o, 0);
    // back-to-back checks on the re-arming instance with issue held high
    do_reset();
    end_cyc_i = 4'd2;
    issue_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("rearm%0d.start", k), r_start, 1);
      chk($sformatf("rearm%0d.startcnt", k), r_cnt, 0);
      tick();
      chk($sformatf("rearm%0d.run1.start", k), r_start, 0);
      chk($sformatf("rearm%0d.run1.cnt", k), r_cnt, 1);
      tick();
      chk($sformatf("rearm%0d.run2.start", k), r_start, 0);
      tick();
      chk($sformatf("rearm%0d.ended", k), r_ended, 1);
      chk($sformatf("rearm%0d.match", k), r_match, 4'hF);
      tick();
      chk($sformatf("rearm%0d.done", k), r_done, k);
      chk($sformatf("rearm%0d.idle.cnt", k), r_cnt, 0);
      chk($sformatf("rearm%0d.idle.started", k), r_started, 0);
      chk($sformatf("rearm%0d.idle.start", k), r_start, 0);
    end
    issue_i = 1'b0;
    tick();
    chk("rearm.final.done", r_done, 3);
    chk("rearm.final.fail", r_fail, 0);
    // reset mid-check with mismatching data in flight
    do_reset();
    spec_val_i = 32'h00000000;
    impl_val_i = 32'hFFFFFFFF;
    chk_mask_i = 4'hF;
    end_cyc_i = 4'd2;
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    tick();
    tick();
    chk("rmid.pre.cnt", cycle_cnt_o, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rmid");
    tick();
    chk("rmid.after.mismatch", mismatch_o, 0);
    chk("rmid.after.started", started_o, 0);
    pass_check("ec0", 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/refinement_check_monitor.md
Name: refinement_check_monitor

Overview:
- Parametrised successor to the single-instruction ILA-vs-RTL verification wrapper logic.
- Sequences one instruction check after an issue: START/STARTED flags, cycle counter, instruction-end detection, second-end flag.
- Adds NCH masked spec-vs-implementation compare channels, runtime-programmable commit cycle, timeout detection, sticky failure and optional re-arm for back-to-back checks.
- Sits in the verification wrapper, between the ILA spec instance and the pipeline under test.

Parameters:
- DW, 8: width of each compared value.
- NCH, 4: number of compare channels.
- CW, 4: cycle counter width.
- CNT_MAX, 6: counter saturation value, must be < 2**CW.
- REARM, 0: 0 = one check per reset; 1 = return to IDLE after each check.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- issue_i  in  1  request to start a check.
- end_cyc_i  in  CW  commit cycle count; sampled at accepted issue.
- spec_val_i  in  NCH*DW  spec values; channel i is bits [i*DW+:DW].
- impl_val_i  in  NCH*DW  implementation values, same packing as spec_val_i.
- chk_mask_i  in  NCH  1 = channel is compared.
- start_o  out  1  one-cycle start pulse.
- started_o  out  1  check in progress.
- cycle_cnt_o  out  CW  cycles since start.
- ended_o  out  1  instruction end reached.
- end2_o  out  1  second-end flag.
- resetted_o  out  1  a reset has been seen.
- match_o  out  NCH  per-channel result of the last compare.
- mismatch_o  out  1  one-cycle pulse on a failed compare.
- timeout_o  out  1  commit cycle unreachable.
- fail_o  out  1  sticky failure.
- checks_done_o  out  8  number of completed checks.

Behaviour:
- Reset (rst=1 at clk edge):
  - Goes to IDLE.
  - start_o, started_o, ended_o, end2_o, mismatch_o, timeout_o, fail_o = 0.
  - cycle_cnt_o = 0, checks_done_o = 0.
  - match_o = all ones.
  - resetted_o <= 1; it is never cleared afterwards.
- FSM states: IDLE, START, RUN, END1, HOLD.
- IDLE:
  - If issue_i=1: go to START and latch end_tgt = (end_cyc_i==0) ? 1 : end_cyc_i.
  - start_o is 1 for exactly the one cycle spent in START.
- START -> RUN: started_o is set on this transition and held.
- Counter:
  - Increments by 1 every cycle while (start_o || started_o) and cycle_cnt_o < CNT_MAX.
  - Saturates at CNT_MAX; never wraps.
- iend = started_o && cycle_cnt_o==end_tgt && !ended_o && resetted_o.
- RUN, in the iend cycle:
  - Compare every channel: match_o[i] <= !chk_mask_i[i] || (impl==spec for channel i).
  - If any channel fails: mismatch_o pulses 1 the next cycle and fail_o <= 1.
  - ended_o <= 1; go to END1.
- RUN timeout:
  - If end_tgt > CNT_MAX and cycle_cnt_o==CNT_MAX: timeout_o <= 1, fail_o <= 1, go to HOLD.
  - No compare is performed; ended_o stays 0.
- END1 (one cycle):
  - end2_o <= 1; checks_done_o increments, saturating at 255.
  - REARM=0: go to HOLD.
  - REARM=1: go to IDLE. On this transition clear started_o, ended_o, end2_o, cycle_cnt_o. match_o, fail_o and timeout_o are kept.
- HOLD: all outputs frozen until rst.
- issue_i outside IDLE is ignored and not queued.
- issue_i in the same cycle as the REARM return to IDLE is ignored; the earliest new issue is accepted one cycle later.
- rst mid-check: aborts immediately to reset values; the in-flight compare is discarded.
- Compare uses only the iend-cycle sample; value changes in any other cycle have no effect.

Test Plan:
- Pass check: rst, then issue_i=1 with end_cyc_i=1, all channels equal (0x5A), mask=4'hF -> start_o pulses in cycle 1; ended_o=1 in cycle 3; match_o=4'hF; mismatch_o never 1; end2_o=1 one cycle after ended_o; checks_done_o=1.
- Masked mismatch: end_cyc_i=3, channel 2 impl=0x11 vs spec=0x10:
  - mask=4'hF -> match_o=4'hB, mismatch_o one-cycle pulse, fail_o=1 sticky.
  - Repeated with mask=4'hB -> match_o=4'hF, fail_o=0.
- Timeout: end_cyc_i=9 with CNT_MAX=6 -> cycle_cnt_o saturates at 6, timeout_o=1, fail_o=1, ended_o=0, state HOLD.
- REARM=1: three issues of end_cyc_i=2 back to back (issue_i held high) -> checks_done_o=3; counter clears between checks; issues asserted during RUN are ignored.
- Reset mid-op: rst asserted while cycle_cnt_o=2 -> next cycle all outputs at reset values, resetted_o=1, no mismatch_o pulse.
- end_cyc_i=0 -> treated as 1; ended_o behaves identically to the first scenario.
